// File: rtl/maxnet_ctrl_if.sv
// Handshake and neuron-bus bundle between the MAXNET array and its
// competition controller.
interface maxnet_ctrl_if #(
   parameter int W = 32
);
   logic         start;
   logic [3:0]   o;
   logic [W-1:0] xo0;
   logic [W-1:0] xo1;
   logic [W-1:0] xo2;
   logic [W-1:0] xo3;
   logic         mux;
   logic         busy;
   logic         done;
   logic [1:0]   winner;
   logic [W-1:0] win_val;
   logic         none;
   logic         timeout;
   logic [7:0]   iter_cnt;

   modport master (
      output start, o, xo0, xo1, xo2, xo3,
      input  mux, busy, done, winner, win_val, none, timeout, iter_cnt
   );

   modport slave (
      input  start, o, xo0, xo1, xo2, xo3,
      output mux, busy, done, winner, win_val, none, timeout, iter_cnt
   );
endinterface

// File: rtl/maxnet_ctrl.sv
// Sequencer for a 4-neuron MAXNET: loads the array, iterates until one
// neuron survives, all die, or the iteration limit expires, then latches the result.
module maxnet_ctrl #(
   parameter int MAX_ITER = 64,
   parameter int W        = 32
) (
   input logic         clk,
   input logic         rst,
   maxnet_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, ITER, DONE} state_t;

   state_t       state;
   state_t       next_state;
   logic [7:0]   cnt;
   logic [2:0]   pop;
   logic [1:0]   low_idx;
   logic [W-1:0] low_val;
   logic         decide;
   logic         mux_d;
   logic         busy_d;
   logic         done_d;

   always_comb begin
      pop = {2'b00, bus.o[0]} + {2'b00, bus.o[1]} + {2'b00, bus.o[2]} + {2'b00, bus.o[3]};
      low_idx = 2'd0;
      if (bus.o[0])      low_idx = 2'd0;
      else if (bus.o[1]) low_idx = 2'd1;
      else if (bus.o[2]) low_idx = 2'd2;
      else if (bus.o[3]) low_idx = 2'd3;
      case (low_idx)
         2'd0:    low_val = bus.xo0;
         2'd1:    low_val = bus.xo1;
         2'd2:    low_val = bus.xo2;
         default: low_val = bus.xo3;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         bus.mux  <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         state    <= next_state;
         bus.mux  <= mux_d;
         bus.busy <= busy_d;
         bus.done <= done_d;
      end
   end

   // A single surviving neuron wins even on the last permitted iteration.
   always_comb begin
      next_state = state;
      decide     = 1'b0;
      case (state)
         IDLE:  if (bus.start) next_state = LOAD1;
         LOAD1: next_state = LOAD2;
         LOAD2: next_state = ITER;
         ITER: begin
            if (pop <= 3'd1 || cnt == 8'(MAX_ITER - 1)) begin
               decide     = 1'b1;
               next_state = DONE;
            end
         end
         DONE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      mux_d  = (next_state == ITER) || (next_state == DONE);
      busy_d = (next_state == LOAD1) || (next_state == LOAD2) || (next_state == ITER);
      done_d = (next_state == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt          <= 8'd0;
         bus.winner   <= 2'd0;
         bus.win_val  <= '0;
         bus.none     <= 1'b0;
         bus.timeout  <= 1'b0;
         bus.iter_cnt <= 8'd0;
      end else begin
         if (state == ITER && !decide) cnt <= cnt + 8'd1;
         else                          cnt <= 8'd0;
         if (decide) begin
            bus.winner   <= (pop == 3'd0) ? 2'd0 : low_idx;
            bus.win_val  <= (pop == 3'd0) ? '0 : low_val;
            bus.none     <= (pop == 3'd0);
            bus.timeout  <= (pop >= 3'd2);
            bus.iter_cnt <= cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_maxnet_ctrl.sv
// Directed checks of the MAXNET controller: win, convergence, extinction,
// timeout, ignored starts and asynchronous reset mid-competition.
module tb_maxnet_ctrl;
   localparam int W = 32;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;
   int   iter_cycles;

   maxnet_ctrl_if #(.W(W)) bus ();

   maxnet_ctrl #(.MAX_ITER(4), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [3:0] ov);
      bus.start = s;
      bus.o     = ov;
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic enterIter();
      applyStimulus(1'b1, 4'b0000);
      nextCycle();
      applyStimulus(1'b0, 4'b0000);
      nextCycle();
      nextCycle();
   endtask

   task automatic checkResult(input string tag, input logic [1:0] w, input logic [31:0] v,
                              input logic n, input logic t, input logic [7:0] ic);
      checkOutput({tag, "_winner"}, {30'd0, bus.winner}, {30'd0, w});
      checkOutput({tag, "_win_val"}, bus.win_val, v);
      checkOutput({tag, "_none"}, {31'd0, bus.none}, {31'd0, n});
      checkOutput({tag, "_timeout"}, {31'd0, bus.timeout}, {31'd0, t});
      checkOutput({tag, "_iter_cnt"}, {24'd0, bus.iter_cnt}, {24'd0, ic});
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b0;
      bus.start  = 1'b0;
      bus.o      = 4'b0000;
      bus.xo0    = 32'h0000_00A0;
      bus.xo1    = 32'h0000_00B1;
      bus.xo2    = 32'h0000_0010;
      bus.xo3    = 32'h0000_00D3;

      nextCycle();
      nextCycle();
      checkOutput("rst_mux", {31'd0, bus.mux}, 32'd0);
      checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
      checkResult("rst", 2'd0, 32'd0, 1'b0, 1'b0, 8'd0);
      rst = 1'b1;

      // Immediate winner: neuron 2 alone on the first ITER cycle
      applyStimulus(1'b1, 4'b0000);
      nextCycle();
      checkOutput("load1_busy", {31'd0, bus.busy}, 32'd1);
      checkOutput("load1_mux", {31'd0, bus.mux}, 32'd0);
      applyStimulus(1'b0, 4'b0000);
      nextCycle();
      checkOutput("load2_busy", {31'd0, bus.busy}, 32'd1);
      checkOutput("load2_mux", {31'd0, bus.mux}, 32'd0);
      nextCycle();
      checkOutput("iter_mux", {31'd0, bus.mux}, 32'd1);
      checkOutput("iter_busy", {31'd0, bus.busy}, 32'd1);
      checkOutput("iter_done", {31'd0, bus.done}, 32'd0);
      applyStimulus(1'b0, 4'b0100);
      nextCycle();
      checkOutput("win_done", {31'd0, bus.done}, 32'd1);
      checkOutput("win_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("win_mux", {31'd0, bus.mux}, 32'd1);
      checkResult("win", 2'd2, 32'h10, 1'b0, 1'b0, 8'd1);
      applyStimulus(1'b0, 4'b0000);
      nextCycle();
      checkOutput("idle_done", {31'd0, bus.done}, 32'd0);
      checkOutput("idle_mux", {31'd0, bus.mux}, 32'd0);
      checkOutput("idle_hold_winner", {30'd0, bus.winner}, 32'd2);

      // Convergence over four iterations, last one on the limit cycle
      enterIter();
      applyStimulus(1'b0, 4'b1111);
      nextCycle();
      checkOutput("conv_done1", {31'd0, bus.done}, 32'd0);
      applyStimulus(1'b0, 4'b0111);
      nextCycle();
      applyStimulus(1'b0, 4'b0011);
      nextCycle();
      checkOutput("conv_busy3", {31'd0, bus.busy}, 32'd1);
      applyStimulus(1'b0, 4'b1000);
      nextCycle();
      checkOutput("conv_done", {31'd0, bus.done}, 32'd1);
      checkResult("conv", 2'd3, 32'hD3, 1'b0, 1'b0, 8'd4);
      applyStimulus(1'b0, 4'b0000);
      nextCycle();

      // All neurons die
      enterIter();
      applyStimulus(1'b0, 4'b0110);
      nextCycle();
      applyStimulus(1'b0, 4'b0000);
      nextCycle();
      checkOutput("none_done", {31'd0, bus.done}, 32'd1);
      checkResult("none", 2'd0, 32'd0, 1'b1, 1'b0, 8'd2);
      nextCycle();

      // Timeout with two neurons held active
      enterIter();
      applyStimulus(1'b0, 4'b0011);
      iter_cycles = 0;
      for (int i = 0; i < 10 && !bus.done; i++) begin
         if (bus.mux && bus.busy) iter_cycles++;
         nextCycle();
      end
      checkOutput("to_done", {31'd0, bus.done}, 32'd1);
      checkOutput("to_iter_cycles", iter_cycles, 32'd4);
      checkResult("to", 2'd0, 32'hA0, 1'b0, 1'b1, 8'd4);
      applyStimulus(1'b1, 4'b0000);
      nextCycle();
      checkOutput("done_start_ignored", {31'd0, bus.busy}, 32'd0);
      applyStimulus(1'b0, 4'b0000);
      nextCycle();

      // Start during ITER ignored; results persist into the next competition
      enterIter();
      applyStimulus(1'b1, 4'b0011);
      nextCycle();
      applyStimulus(1'b0, 4'b0010);
      nextCycle();
      checkResult("ign", 2'd1, 32'hB1, 1'b0, 1'b0, 8'd2);
      applyStimulus(1'b0, 4'b0000);
      nextCycle();
      checkOutput("ign_no_restart", {31'd0, bus.busy}, 32'd0);
      applyStimulus(1'b1, 4'b0000);
      nextCycle();
      checkOutput("persist_busy", {31'd0, bus.busy}, 32'd1);
      checkResult("persist", 2'd1, 32'hB1, 1'b0, 1'b0, 8'd2);
      applyStimulus(1'b0, 4'b0000);
      nextCycle();
      nextCycle();
      applyStimulus(1'b0, 4'b0100);
      nextCycle();
      checkResult("persist_new", 2'd2, 32'h10, 1'b0, 1'b0, 8'd1);
      applyStimulus(1'b0, 4'b0000);
      nextCycle();

      // Asynchronous reset in the third ITER cycle
      enterIter();
      applyStimulus(1'b0, 4'b0011);
      nextCycle();
      nextCycle();
      #2 rst = 1'b0;
      #1;
      checkOutput("arst_mux", {31'd0, bus.mux}, 32'd0);
      checkOutput("arst_busy", {31'd0, bus.busy}, 32'd0);
      checkResult("arst", 2'd0, 32'd0, 1'b0, 1'b0, 8'd0);
      nextCycle();
      nextCycle();
      checkOutput("arst_no_done", {31'd0, bus.done}, 32'd0);
      rst = 1'b1;
      applyStimulus(1'b1, 4'b0000);
      nextCycle();
      checkOutput("post_rst_start", {31'd0, bus.busy}, 32'd1);
      applyStimulus(1'b0, 4'b0000);
      nextCycle();
      nextCycle();
      applyStimulus(1'b0, 4'b1000);
      nextCycle();
      checkOutput("post_rst_done", {31'd0, bus.done}, 32'd1);
      checkResult("post_rst", 2'd3, 32'hD3, 1'b0, 1'b0, 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
